// File: rtl/hash_stream_pkg.sv
// Shared constants and types for the hash-table response stream path.
package hash_stream_pkg;

  // Response word layout and output beat width
  localparam int RESP_WIDTH = 64;
  localparam int BEAT_WIDTH = 32;
  localparam int FLAG_LSB   = 60;
  localparam int NUM_FLAGS  = 4;

  // Status flag indices, relative to FLAG_LSB
  localparam int NO_DEL      = 0;
  localparam int NO_SPACE    = 1;
  localparam int NOT_FOUND   = 2;
  localparam int KEY_PRESENT = 3;

  // Serializer state: nothing held, low beat on the bus, high beat on the bus
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOW   = 2'd1,
    HIGH  = 2'd2
  } ser_state_e;

endpackage

// File: rtl/last_flag_fifo.sv
// 1-bit FIFO holding the last flag of each accepted request until its response
// has been fully sent. Pointers carry one extra wrap bit to tell full from empty.
// Both the head and the entry behind it are visible so the serializer can pick
// up the next response's flag in the same cycle the current one is popped.
module last_flag_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   din,
  input  logic                   pop,
  output logic                   head,
  output logic                   second,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic            mem [DEPTH];
  logic [AW:0]     wr_ptr_reg;
  logic [AW:0]     rd_ptr_reg;
  logic [AW-1:0]   rd_addr_next;
  logic            do_push;
  logic            do_pop;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign count = wr_ptr_reg - rd_ptr_reg;

  // A pop frees a slot, so a push into a full FIFO is accepted when it pops too
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rd_addr_next = rd_ptr_reg[AW-1:0] + AW'(1);
  assign head         = mem[rd_ptr_reg[AW-1:0]];
  assign second       = mem[rd_addr_next];

  // Pointer update; reset discards all stored flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  // Flag storage; contents are meaningless until written, so no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

endmodule

// File: rtl/hash_response_serializer.sv
// Splits each 64-bit hash-table response into two 32-bit stream beats, re-attaches
// the request last flag (tracked in-order through last_flag_fifo) to the high beat,
// and keeps saturating response / status-flag counters plus sticky error flags.
module hash_response_serializer
  import hash_stream_pkg::*;
#(
  parameter int DATA_WIDTH      = 25,
  parameter int LAST_FIFO_DEPTH = 16,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid_i,
  input  logic                           req_ready_i,
  input  logic                           req_last_i,
  input  logic [RESP_WIDTH-1:0]          resp_data_i,
  input  logic                           resp_valid_i,
  output logic                           resp_ready_o,
  output logic [BEAT_WIDTH-1:0]          m_data_o,
  output logic                           m_valid_o,
  output logic                           m_last_o,
  input  logic                           m_ready_i,
  output logic [CNT_WIDTH-1:0]           cnt_resp_o,
  output logic [NUM_FLAGS*CNT_WIDTH-1:0] cnt_flag_o,
  output logic                           err_overflow_o,
  output logic                           err_underflow_o
);

  localparam int PTR_W = $clog2(LAST_FIFO_DEPTH);

  ser_state_e             state_reg;
  ser_state_e             state_next;
  logic [RESP_WIDTH-1:0]  resp_mask;
  logic [RESP_WIDTH-1:0]  resp_word;
  logic [RESP_WIDTH-1:0]  word_reg;
  logic                   last_reg;
  logic                   owned_reg;
  logic                   accept;
  logic                   high_done;
  logic                   entry_avail;
  logic                   entry_last;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_head;
  logic                   fifo_second;
  logic [PTR_W:0]         fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;

  logic [BEAT_WIDTH-1:0]  m_data_reg;
  logic [BEAT_WIDTH-1:0]  m_data_next;
  logic                   m_valid_reg;
  logic                   m_valid_next;
  logic                   m_last_reg;
  logic                   m_last_next;

  logic [CNT_WIDTH-1:0]   cnt_resp_reg;
  logic                   err_overflow_reg;
  logic                   err_underflow_reg;

  // Only the read-data field and the status flags are meaningful; the gap
  // between them is forced to zero so stray bits never reach the stream.
  for (genvar gi = 0; gi < RESP_WIDTH; gi++) begin : g_mask
    assign resp_mask[gi] = (gi < DATA_WIDTH) || (gi >= FLAG_LSB);
  end
  assign resp_word = resp_data_i & resp_mask;

  // Handshakes: a new word is taken when idle, or as the high beat leaves
  assign high_done    = (state_reg == HIGH) && m_ready_i;
  assign resp_ready_o = (state_reg == EMPTY) || high_done;
  assign accept       = resp_valid_i && resp_ready_o;

  // Only pop when the outgoing response actually took a FIFO entry
  assign fifo_push = req_valid_i && req_ready_i;
  assign fifo_pop  = high_done && owned_reg;

  last_flag_fifo #(
    .DEPTH (LAST_FIFO_DEPTH)
  ) u_last_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (fifo_push),
    .din    (req_last_i),
    .pop    (fifo_pop),
    .head   (fifo_head),
    .second (fifo_second),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Pick the flag belonging to the word being accepted; if the head is being
  // popped this cycle the new word's flag is the entry behind it.
  always_comb begin
    entry_avail = 1'b0;
    entry_last  = 1'b1;
    if (fifo_pop) begin
      entry_avail = (fifo_count > (PTR_W+1)'(1));
      if (entry_avail) entry_last = fifo_second;
    end else begin
      entry_avail = !fifo_empty;
      if (entry_avail) entry_last = fifo_head;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= EMPTY;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY: if (resp_valid_i) state_next = LOW;
      LOW:   if (m_ready_i)    state_next = HIGH;
      HIGH:  if (m_ready_i)    state_next = resp_valid_i ? LOW : EMPTY;
      default:                 state_next = EMPTY;
    endcase
  end

  // Output decode for the beat presented in the next cycle
  always_comb begin
    m_data_next  = '0;
    m_valid_next = 1'b0;
    m_last_next  = 1'b0;
    case (state_next)
      LOW: begin
        m_valid_next = 1'b1;
        m_data_next  = accept ? resp_word[BEAT_WIDTH-1:0] : word_reg[BEAT_WIDTH-1:0];
      end
      HIGH: begin
        m_valid_next = 1'b1;
        m_data_next  = word_reg[RESP_WIDTH-1:BEAT_WIDTH];
        m_last_next  = last_reg;
      end
      default: ;
    endcase
  end

  // Registered stream outputs; they only change on a handshake or new word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_data_reg  <= '0;
      m_valid_reg <= 1'b0;
      m_last_reg  <= 1'b0;
    end else begin
      m_data_reg  <= m_data_next;
      m_valid_reg <= m_valid_next;
      m_last_reg  <= m_last_next;
    end
  end

  assign m_data_o  = m_data_reg;
  assign m_valid_o = m_valid_reg;
  assign m_last_o  = m_last_reg;

  // Hold the accepted word with its last flag and FIFO-ownership marker
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_reg  <= '0;
      last_reg  <= 1'b0;
      owned_reg <= 1'b0;
    end else if (accept) begin
      word_reg  <= resp_word;
      last_reg  <= entry_last;
      owned_reg <= entry_avail;
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_overflow_reg  <= 1'b0;
      err_underflow_reg <= 1'b0;
    end else begin
      if (fifo_push && fifo_full && !fifo_pop) err_overflow_reg  <= 1'b1;
      if (accept && !entry_avail)             err_underflow_reg <= 1'b1;
    end
  end

  assign err_overflow_o  = err_overflow_reg;
  assign err_underflow_o = err_underflow_reg;

  // Completed-response counter, saturating at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               cnt_resp_reg <= '0;
    else if (high_done && (cnt_resp_reg != '1)) cnt_resp_reg <= cnt_resp_reg + CNT_WIDTH'(1);
  end

  assign cnt_resp_o = cnt_resp_reg;

  // Per-flag counters, bumped when a response carrying that flag completes
  for (genvar gi = 0; gi < NUM_FLAGS; gi++) begin : g_flag_cnt
    logic [CNT_WIDTH-1:0] cnt_reg;

    // Saturating count of completed responses with flag gi set
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_reg <= '0;
      end else if (high_done && word_reg[FLAG_LSB+gi] && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + CNT_WIDTH'(1);
      end
    end

    assign cnt_flag_o[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_reg;
  end

endmodule

// File: tb/tb_hash_response_serializer.sv
// Directed bench for hash_response_serializer: stimulus tasks push expected beats
// into a queue, and a monitor compares every accepted output beat against it.
module tb_hash_response_serializer;

  localparam int DW    = 25;
  localparam int DEPTH = 16;
  localparam int CW    = 3;   // narrow counters so saturation is reachable

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid_i, req_ready_i, req_last_i;
  logic [63:0]       resp_data_i;
  logic              resp_valid_i, resp_ready_o;
  logic [31:0]       m_data_o;
  logic              m_valid_o, m_last_o, m_ready_i;
  logic [CW-1:0]     cnt_resp_o;
  logic [4*CW-1:0]   cnt_flag_o;
  logic              err_overflow_o, err_underflow_o;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  logic  model_last_q[$];
  int    beat_cyc[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;

  hash_response_serializer #(
    .DATA_WIDTH      (DW),
    .LAST_FIFO_DEPTH (DEPTH),
    .CNT_WIDTH       (CW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid_i     (req_valid_i),
    .req_ready_i     (req_ready_i),
    .req_last_i      (req_last_i),
    .resp_data_i     (resp_data_i),
    .resp_valid_i    (resp_valid_i),
    .resp_ready_o    (resp_ready_o),
    .m_data_o        (m_data_o),
    .m_valid_o       (m_valid_o),
    .m_last_o        (m_last_o),
    .m_ready_i       (m_ready_i),
    .cnt_resp_o      (cnt_resp_o),
    .cnt_flag_o      (cnt_flag_o),
    .err_overflow_o  (err_overflow_o),
    .err_underflow_o (err_underflow_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every accepted beat is compared with the head of the scoreboard
  always @(negedge clk) begin
    beat_t e;
    if (reset && m_valid_o && m_ready_i) begin
      beat_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat_unexpected actual data=%h last=%b required no beat", m_data_o, m_last_o);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", 64'(m_data_o), 64'(e.data));
        check("beat_last", 64'(m_last_o), 64'(e.last));
        $display("beat cyc=%0d data=%h last=%b", cyc, m_data_o, m_last_o);
      end
    end
  end

  // Expected beats for one response; an empty last-flag model means last=1
  task automatic expect_resp(input logic [63:0] w);
    beat_t b;
    logic  l;
    if (model_last_q.size() > 0) l = model_last_q.pop_front();
    else                         l = 1'b1;
    b.data = w[31:0];  b.last = 1'b0; exp_q.push_back(b);
    b.data = w[63:32]; b.last = l;    exp_q.push_back(b);
  endtask

  task automatic send_req(input logic l);
    req_valid_i = 1'b1; req_ready_i = 1'b1; req_last_i = l;
    @(posedge clk); #1;
    req_valid_i = 1'b0; req_ready_i = 1'b0; req_last_i = 1'b0;
    if (model_last_q.size() < DEPTH) model_last_q.push_back(l);
    $display("req last=%b", l);
  endtask

  task automatic send_resp(input logic [63:0] w);
    bit acc = 1'b0;
    int n = 0;
    expect_resp(w);
    resp_data_i = w; resp_valid_i = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk); acc = resp_ready_o;
      @(posedge clk); #1;
      n++;
    end
    resp_valid_i = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL resp_accept_timeout actual=not accepted required=accepted word=%h", w);
    end else begin
      $display("resp word=%h accepted", w);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    model_last_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w;
    logic [16:0] pat;
    int          base;
    bit          acc;
    int          n;

    reset = 1'b0; req_valid_i = 0; req_ready_i = 0; req_last_i = 0;
    resp_data_i = '0; resp_valid_i = 0; m_ready_i = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Reset state
    check("rst_valid", 64'(m_valid_o), 64'(0));
    check("rst_data", 64'(m_data_o), 64'(0));
    check("rst_last", 64'(m_last_o), 64'(0));
    check("rst_cnt_resp", 64'(cnt_resp_o), 64'(0));
    check("rst_cnt_flag", 64'(cnt_flag_o), 64'(0));
    check("rst_ovf", 64'(err_overflow_o), 64'(0));
    check("rst_unf", 64'(err_underflow_o), 64'(0));
    check("rst_ready", 64'(resp_ready_o), 64'(1));

    // Test 1: single response, last=1; a request without ready is not recorded
    req_valid_i = 1'b1; req_ready_i = 1'b0; req_last_i = 1'b0;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    send_req(1'b1);
    m_ready_i = 1'b1;
    send_resp(64'h8000_0000_0000_0ABC);
    check("t1_latency", 64'(m_valid_o), 64'(1));
    drain();
    check("t1_cnt_resp", 64'(cnt_resp_o), 64'(1));
    check("t1_cnt_flag", 64'(cnt_flag_o), 64'h200);

    // Test 2: three back-to-back responses, last only on beat 6, no bubbles
    send_req(1'b0); send_req(1'b0); send_req(1'b1);
    base = beat_cyc.size();
    send_resp(64'h1000_0000_0000_0001);
    send_resp(64'h2000_0000_0000_0002);
    send_resp(64'h4000_0000_0000_0003);
    drain();
    if (beat_cyc.size() >= base + 6)
      check("t2_no_bubble", 64'(beat_cyc[base+5] - beat_cyc[base]), 64'(5));
    else
      check("t2_beat_count", 64'(beat_cyc.size() - base), 64'(6));
    check("t2_cnt_resp", 64'(cnt_resp_o), 64'(4));
    check("t2_cnt_flag", 64'(cnt_flag_o), 64'h249);

    // Test 3: stall during LOW for 5 cycles with a second response waiting
    send_req(1'b1); send_req(1'b0);
    m_ready_i = 1'b0;
    w = 64'h0000_0000_0123_4567;
    send_resp(w);
    expect_resp(64'h2000_0000_0000_00FF);
    resp_data_i = 64'h2000_0000_0000_00FF; resp_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_valid", 64'(m_valid_o), 64'(1));
      check("t3_data", 64'(m_data_o), 64'(w[31:0]));
      check("t3_last", 64'(m_last_o), 64'(0));
      check("t3_ready", 64'(resp_ready_o), 64'(0));
      @(posedge clk); #1;
    end
    m_ready_i = 1'b1;
    acc = 1'b0; n = 0;
    while (!acc && n < 100) begin
      @(negedge clk); acc = resp_ready_o;
      @(posedge clk); #1;
      n++;
    end
    resp_valid_i = 1'b0;
    check("t3_second_accepted", 64'(acc), 64'(1));
    drain();

    // Test 4: 17 requests into a 16-deep FIFO, then 16 responses in order
    do_reset();
    pat = 17'h1A5C3;
    for (int i = 0; i < 17; i++) begin
      if (i == 16) check("t4_no_ovf_at_16", 64'(err_overflow_o), 64'(0));
      send_req(pat[i]);
    end
    check("t4_ovf", 64'(err_overflow_o), 64'(1));
    for (int i = 0; i < 16; i++) send_resp({4'(i), 35'd0, 25'(i + 100)});
    drain();
    check("t4_unf", 64'(err_underflow_o), 64'(0));
    check("t4_cnt_resp_sat", 64'(cnt_resp_o), 64'(7));
    check("t4_cnt_flag_sat", 64'(cnt_flag_o), 64'hFFF);

    // Test 5: response with the FIFO empty
    send_resp(64'h4000_0000_0000_0055);
    drain();
    check("t5_unf", 64'(err_underflow_o), 64'(1));
    check("t5_cnt_resp_sat", 64'(cnt_resp_o), 64'(7));

    // Test 6: reset while the high beat is stalled
    do_reset();
    send_req(1'b0); send_req(1'b0); send_req(1'b0);
    m_ready_i = 1'b0;
    send_resp(64'h8000_0000_0000_0123);
    m_ready_i = 1'b1;
    @(posedge clk); #1;
    m_ready_i = 1'b0;
    @(negedge clk);
    check("t6_high_valid", 64'(m_valid_o), 64'(1));
    reset = 1'b0;
    #1;
    check("t6_rst_valid", 64'(m_valid_o), 64'(0));
    check("t6_rst_data", 64'(m_data_o), 64'(0));
    exp_q.delete();
    model_last_q.delete();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    check("t6_cnt_resp", 64'(cnt_resp_o), 64'(0));
    check("t6_cnt_flag", 64'(cnt_flag_o), 64'(0));
    check("t6_ovf", 64'(err_overflow_o), 64'(0));
    check("t6_unf", 64'(err_underflow_o), 64'(0));
    check("t6_valid", 64'(m_valid_o), 64'(0));
    check("t6_ready", 64'(resp_ready_o), 64'(1));
    m_ready_i = 1'b1;
    send_resp(64'h1000_0000_0000_0777);
    drain();
    check("t6_fifo_flushed_unf", 64'(err_underflow_o), 64'(1));
    check("t6_post_cnt_resp", 64'(cnt_resp_o), 64'(1));
    check("t6_post_cnt_flag", 64'(cnt_flag_o), 64'h001);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
